// File: rtl/diff_bcd_pkg.sv
// diff_bcd_pkg: shared constants and state encoding for the difference-to-BCD converter
package diff_bcd_pkg;
    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 3;
    localparam int ITER_COUNT = 8;
    localparam int CNT_W      = $clog2(ITER_COUNT);
    localparam int SCR_W      = DIGIT_W * NUM_DIGITS;
    localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/diff_bcd_converter_add3.sv
// bcd_add3: double-dabble digit correction (i_d >= 5 ? i_d + 3 : i_d)
//   i_d  BCD scratch digit before the shift
//   o_d  corrected digit
module bcd_add3 import diff_bcd_pkg::*; (
    input  logic [DIGIT_W-1:0] i_d,
    output logic [DIGIT_W-1:0] o_d
);
    assign o_d = (i_d >= ADD3_THRESH) ? i_d + 4'd3 : i_d;
endmodule

// File: rtl/diff_bcd_converter.sv
// diff_bcd_converter: iterative sign + 3-digit BCD conversion of the subtractor output
//   clk, rst_n        clock, asynchronous active-low reset
//   start, din        conversion request and 8-bit difference
//   busy, done        conversion in progress / one-cycle result-valid pulse
//   sign, bcd_*       sign and hundreds/tens/ones digits, held until the next done
module diff_bcd_converter import diff_bcd_pkg::*; #(
    parameter bit SIGNED_MODE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic       sign,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
);
    state_t             r_state, w_next;
    logic [7:0]         r_mag;
    logic [SCR_W-1:0]   r_scr, w_adj, w_scr_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign_cap, r_sign;
    logic [3:0]         r_hund, r_tens, r_ones;
    logic               w_neg_in, w_accept, w_last;
    logic [8:0]         w_neg;

    assign w_neg_in  = SIGNED_MODE && din[7];
    // 9-bit negation so that -128 yields magnitude 128 without wrapping
    assign w_neg     = 9'd0 - {1'b0, din};
    assign w_accept  = start && (r_state != SHIFT);
    assign w_last    = (r_state == SHIFT) && (r_cnt == '0);

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_d(r_scr[g*DIGIT_W +: DIGIT_W]),
                .o_d(w_adj[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // the corrected hundreds MSB is always 0 for 8-bit inputs, so it drops out of the shift
    assign w_scr_nxt = SCR_W'({w_adj, r_mag[7]});

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = w_accept ? SHIFT : w_last ? DONE : (r_state == DONE) ? IDLE : r_state;
        busy   = (r_state == SHIFT);
        done   = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag      <= '0;
            r_scr      <= '0;
            r_cnt      <= '0;
            r_sign_cap <= 1'b0;
            r_sign     <= 1'b0;
            r_hund     <= '0;
            r_tens     <= '0;
            r_ones     <= '0;
        end else if (w_accept) begin
            r_mag      <= w_neg_in ? w_neg[7:0] : din;
            r_sign_cap <= w_neg_in;
            r_scr      <= '0;
            r_cnt      <= CNT_W'(ITER_COUNT - 1);
        end else if (r_state == SHIFT) begin
            r_scr <= w_scr_nxt;
            r_mag <= {r_mag[6:0], 1'b0};
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_sign                     <= r_sign_cap;
                {r_hund, r_tens, r_ones}   <= w_scr_nxt;
            end
        end
    end

    assign sign     = r_sign;
    assign bcd_hund = r_hund;
    assign bcd_tens = r_tens;
    assign bcd_ones = r_ones;
endmodule

// File: tb/tb_diff_bcd_converter.sv
// tb_diff_bcd_converter: directed table-driven check of signed and unsigned converters
module tb_diff_bcd_converter;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0] din = '0;
    logic       bs, ds, ss, bu, du, su;
    logic [3:0] hs, ts, os, hu, tu, ou;
    int         n_cmp = 0, n_err = 0;

    typedef struct {
        logic [7:0]  din;
        logic [12:0] exp_s;
        logic [12:0] exp_u;
    } vec_t;
    vec_t vecs[10];

    diff_bcd_converter #(.SIGNED_MODE(1'b1)) u_s (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .busy(bs), .done(ds),
        .sign(ss), .bcd_hund(hs), .bcd_tens(ts), .bcd_ones(os)
    );
    diff_bcd_converter #(.SIGNED_MODE(1'b0)) u_u (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .busy(bu), .done(du),
        .sign(su), .bcd_hund(hu), .bcd_tens(tu), .bcd_ones(ou)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [7:0] v);
        din   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // entered at the negedge right after the accepting edge; leaves in the done cycle
    task automatic conv(input string nm, input logic [12:0] es, input logic [12:0] eu, input int inj);
        int nb_s = 0, nb_u = 0, nd = 0;
        for (int i = 0; i < 8; i++) begin
            nb_s += int'(bs);
            nb_u += int'(bu);
            nd   += int'(ds) + int'(du);
            if (i == inj) begin
                start = 1'b1;
                din   = 8'd99;
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk({nm, " busy_s"}, nb_s, 8);
        chk({nm, " busy_u"}, nb_u, 8);
        chk({nm, " early_done"}, nd, 0);
        chk({nm, " done_s"}, {bs, ds}, 2'b01);
        chk({nm, " done_u"}, {bu, du}, 2'b01);
        chk({nm, " val_s"}, {ss, hs, ts, os}, es);
        chk({nm, " val_u"}, {su, hu, tu, ou}, eu);
    endtask

    initial begin
        int act;
        vecs[0] = '{8'hFF, {1'b1, 12'h001}, {1'b0, 12'h255}};
        vecs[1] = '{8'hF6, {1'b1, 12'h010}, {1'b0, 12'h246}};
        vecs[2] = '{8'h80, {1'b1, 12'h128}, {1'b0, 12'h128}};
        vecs[3] = '{8'h7F, {1'b0, 12'h127}, {1'b0, 12'h127}};
        vecs[4] = '{8'h00, {1'b0, 12'h000}, {1'b0, 12'h000}};
        vecs[5] = '{8'h2A, {1'b0, 12'h042}, {1'b0, 12'h042}};
        vecs[6] = '{8'hC8, {1'b1, 12'h056}, {1'b0, 12'h200}};
        vecs[7] = '{8'h01, {1'b0, 12'h001}, {1'b0, 12'h001}};
        vecs[8] = '{8'h63, {1'b0, 12'h099}, {1'b0, 12'h099}};
        vecs[9] = '{8'h64, {1'b0, 12'h100}, {1'b0, 12'h100}};

        @(negedge clk);
        chk("reset_s", {bs, ds, ss, hs, ts, os}, 0);
        chk("reset_u", {bu, du, su, hu, tu, ou}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].din);
            conv($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_u, -1);
            @(negedge clk);
            chk($sformatf("vec%0d idle", i), {bs, ds, bu, du}, 0);
        end

        launch(8'd42);
        conv("ignore", {1'b0, 12'h042}, {1'b0, 12'h042}, 2);
        launch(8'd7);
        conv("b2b", {1'b0, 12'h007}, {1'b0, 12'h007}, -1);

        @(negedge clk);
        launch(8'd200);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_s", {bs, ds, ss, hs, ts, os}, 0);
        chk("abort_u", {bu, du, su, hu, tu, ou}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            act += int'(bs | ds | bu | du);
            @(negedge clk);
        end
        chk("abort_quiet", act, 0);
        launch(8'd0);
        conv("zero", 13'h0000, 13'h0000, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
